// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared types, widths and saturation helper for mac_sequencer
package mac_pkg;

  localparam int ACC_WIDTH = 40;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    MUL_START,
    MUL_WAIT,
    ACC,
    RESULT
  } mac_seq_state_t;

  // Signed limit of a w-bit quantity widened to the accumulator: max for neg=0, min for neg=1.
  function automatic logic [ACC_WIDTH-1:0] sat_limit(input int unsigned w, input logic neg);
    logic [ACC_WIDTH-1:0] max_v;
    max_v = (ACC_WIDTH'(1) << (w - 1)) - ACC_WIDTH'(1);
    return neg ? ~max_v : max_v;
  endfunction

endpackage

// File: rtl/mac_term_counter.sv
// rtl/mac_term_counter.sv - job term counter with load, decrement and last/zero flags
module mac_term_counter
  import mac_pkg::*;
#(
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 dec_i,
  output logic                 last_o,
  output logic                 zero_o
);

  logic [LEN_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = len_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = (count_q == LEN_WIDTH'(1));
  assign zero_o = (count_q == '0);

endmodule

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - dot-product job sequencer for the Booth multiplier / 40-bit accumulator
// Optional result clamping to the signed product range is enabled with MAC_SEQ_SAT_EN.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_start,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic                  mul_start,
  output logic [DATA_WIDTH-1:0] mul_m,
  output logic [DATA_WIDTH-1:0] mul_q,
  input  logic                  mul_ready,
  output logic                  clr_acc,
  output logic                  acc_en,
  input  logic [ACC_WIDTH-1:0]  acc_in,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WIDTH-1:0]  res_data
`ifdef MAC_SEQ_SAT_EN
  ,
  output logic                  res_sat
`endif
);

  mac_seq_state_t        state_q;
  logic                  busy_q, in_ready_q, mul_start_q, clr_acc_q, acc_en_q, res_valid_q;
  logic                  wait_armed_q;
  logic [DATA_WIDTH-1:0] mul_m_q, mul_q_q;
  logic                  cnt_load, cnt_dec, cnt_last, cnt_zero;

  assign cnt_load = (state_q == IDLE) && cmd_start;
  assign cnt_dec  = (state_q == ACC);

  mac_term_counter #(
    .LEN_WIDTH(LEN_WIDTH)
  ) u_term_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (cnt_load),
    .len_i  (cfg_len),
    .dec_i  (cnt_dec),
    .last_o (cnt_last),
    .zero_o (cnt_zero)
  );

  // Each output register is set on entry to the state that owns it, so it tracks state_q exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      in_ready_q   <= 1'b0;
      mul_start_q  <= 1'b0;
      clr_acc_q    <= 1'b0;
      acc_en_q     <= 1'b0;
      res_valid_q  <= 1'b0;
      wait_armed_q <= 1'b0;
      mul_m_q      <= '0;
      mul_q_q      <= '0;
    end else begin
      mul_start_q <= 1'b0;
      clr_acc_q   <= 1'b0;
      acc_en_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_start) begin
            state_q   <= CLEAR;
            busy_q    <= 1'b1;
            clr_acc_q <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt_zero) begin
            state_q     <= RESULT;
            res_valid_q <= 1'b1;
          end else begin
            state_q    <= FETCH;
            in_ready_q <= 1'b1;
          end
        end
        FETCH: begin
          if (in_valid && in_ready_q) begin
            mul_m_q     <= in_a;
            mul_q_q     <= in_b;
            in_ready_q  <= 1'b0;
            mul_start_q <= 1'b1;
            state_q     <= MUL_START;
          end
        end
        MUL_START: begin
          state_q      <= MUL_WAIT;
          wait_armed_q <= 1'b0;
        end
        MUL_WAIT: begin
          // The first wait cycle may still see the ready from before the start pulse.
          if (!wait_armed_q) begin
            wait_armed_q <= 1'b1;
          end else if (mul_ready) begin
            state_q  <= ACC;
            acc_en_q <= 1'b1;
          end
        end
        ACC: begin
          if (cnt_last) begin
            state_q     <= RESULT;
            res_valid_q <= 1'b1;
          end else begin
            state_q    <= FETCH;
            in_ready_q <= 1'b1;
          end
        end
        RESULT: begin
          if (res_ready) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
  assign mul_start = mul_start_q;
  assign mul_m     = mul_m_q;
  assign mul_q     = mul_q_q;
  assign clr_acc   = clr_acc_q;
  assign acc_en    = acc_en_q;
  assign res_valid = res_valid_q;

`ifdef MAC_SEQ_SAT_EN
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = sat_limit(2 * DATA_WIDTH, 1'b0);
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = sat_limit(2 * DATA_WIDTH, 1'b1);

  logic acc_over, acc_under;
  assign acc_over  = $signed(acc_in) > $signed(SAT_MAX);
  assign acc_under = $signed(acc_in) < $signed(SAT_MIN);

  assign res_data = !res_valid_q ? '0 :
                    acc_over     ? SAT_MAX :
                    acc_under    ? SAT_MIN : acc_in;
  assign res_sat  = res_valid_q && (acc_over || acc_under);
`else
  // The accumulator is frozen in RESULT, so the combinational view is stable for the handshake.
  assign res_data = res_valid_q ? acc_in : '0;
`endif

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Control unit that runs one dot-product job on the shared MAC datapath: a serial Booth multiplier feeding a 40-bit accumulator. It accepts a job length, clears the accumulator, pulls operand pairs from a valid/ready stream and issues one multiply per pair. After each product it pulses an accumulate, then presents the final 40-bit sum on a valid/ready result port. It sits between the operand source (buffer or host) and the multiplier/accumulator pair and drives their `start`, `clr_acc` and `acc_en` controls.

## Interface
- Parameters
  - `DATA_WIDTH`, 16: operand width; the product is 2*`DATA_WIDTH`.
  - `LEN_WIDTH`, 8: width of the job-length field; maximum job is 2^`LEN_WIDTH`-1 terms.
- Ports
  - Clock and reset: one clock, `clk`; reset `rst_n`, asynchronous, active-low.
  - `clk` input, 1: rising-edge clock.
  - `rst_n` input, 1: asynchronous active-low reset.
  - `cmd_start` input, 1: job request; sampled only in IDLE.
  - `cfg_len` input, `LEN_WIDTH`: number of terms; captured with `cmd_start`.
  - `busy` output, 1: high in every state except IDLE.
  - `in_valid` input, 1: operand pair valid.
  - `in_ready` output, 1: sequencer accepts a pair.
  - `in_a` input, `DATA_WIDTH`: signed multiplicand.
  - `in_b` input, `DATA_WIDTH`: signed multiplier.
  - `mul_start` output, 1: one-cycle start pulse to the multiplier.
  - `mul_m` output, `DATA_WIDTH`: registered multiplicand.
  - `mul_q` output, `DATA_WIDTH`: registered multiplier.
  - `mul_ready` input, 1: multiplier done/idle flag.
  - `clr_acc` output, 1: accumulator clear pulse.
  - `acc_en` output, 1: accumulate pulse.
  - `acc_in` input, 40: current accumulator value.
  - `res_valid` output, 1: result valid.
  - `res_ready` input, 1: result consumer ready.
  - `res_data` output, 40: signed result.
  - `res_sat` output, 1: saturation occurred; present only with the macro.

## Operation
- Reset value: every output is 0; `mul_m`/`mul_q` = 0; state = IDLE; term counter = 0.
- IDLE
  - `cmd_start`=1 captures `cfg_len` into the term counter and moves to CLEAR.
  - `cmd_start` in any other state is ignored; commands are not queued.
- CLEAR: `clr_acc`=1 for one cycle. Next state is RESULT if the captured length is 0, otherwise FETCH.
- FETCH
  - `in_ready`=1.
  - On `in_valid && in_ready`, `in_a`/`in_b` are registered into `mul_m`/`mul_q`; next state is MUL_START.
  - `mul_m`/`mul_q` stay stable until the next accepted pair.
- MUL_START: `mul_start`=1 for one cycle, then MUL_WAIT.
- MUL_WAIT
  - `mul_ready` is ignored on the first MUL_WAIT cycle; this is the guard against a stale ready.
  - From the second cycle on, `mul_ready`=1 moves to ACC.
  - There is no timeout.
- ACC
  - `acc_en`=1 for one cycle; the term counter decrements.
  - If the counter was 1, next state is RESULT; otherwise FETCH.
- RESULT
  - `res_valid`=1; `res_data` is derived from `acc_in`.
  - Held stable until `res_valid && res_ready`, then IDLE.
- Control pulses are registered outputs and never overlap: `clr_acc`, `acc_en` and `mul_start` are mutually exclusive.
- A handshake on `res_ready` and a `cmd_start` in the same cycle: `cmd_start` is ignored, because the state is not yet IDLE.
- Reset mid-job returns to IDLE immediately. The accumulator is not cleared by this block outside CLEAR.
- Arithmetic: no arithmetic is done in this block except the saturation option below; the term counter is unsigned `LEN_WIDTH`.

## Timing
- `cmd_start` at cycle 0 gives CLEAR at cycle 1 and FETCH (`in_ready`=1) at cycle 2.
- A pair accepted at cycle t gives `mul_start` at t+1 and MUL_WAIT from t+2.
- ACC occurs one cycle after `mul_ready` is sampled high; the next FETCH follows one cycle after ACC.
- Per-term overhead beyond the multiplier latency is 3 cycles (FETCH, MUL_START, ACC) with `in_valid` held high.
- `res_valid` rises one cycle after the last ACC. `acc_in` already holds the final sum at that point.
- A zero-length job has `res_valid` at cycle 2 with `res_data`=0.

## Configuration
- Macro: `MAC_SEQ_SAT_EN`.
- Defined:
  - `res_data` is `acc_in` clamped to the signed 2*`DATA_WIDTH` range, sign-extended to 40 bits.
  - `res_sat`=1 with `res_valid` when clamping occurred.
- Undefined:
  - `res_data` = `acc_in` unchanged.
  - The `res_sat` port is not present.

## Structure
- Package `mac_pkg`:
  - `ACC_WIDTH`=40.
  - State enum `mac_seq_state_t` with IDLE, CLEAR, FETCH, MUL_START, MUL_WAIT, ACC, RESULT.
  - Saturation limit function taking the width as a parameter.
- Sub-module `mac_term_counter`: load, decrement, `last` flag.
- The FSM and the operand registers stay in the top module.

## Test plan
The bench instantiates the real multiplier and accumulator.
- Job sum: `cfg_len`=3, pairs (3,4), (-2,5), (7,-1) -> one `res_valid`, `res_data`=40'hFF_FFFF_FFFB (-5), exactly 3 `acc_en` and 3 `mul_start` pulses.
- Zero length: `cfg_len`=0 -> `clr_acc` at cycle 1, `res_valid` at cycle 2, `res_data`=0, no `in_ready`.
- Backpressure:
  - `in_valid` low for 5 cycles between pairs: `mul_m`/`mul_q` stay stable.
  - `res_ready` low for 4 cycles: `res_valid` and `res_data` stay constant.
  - Then `busy`=0 in the cycle after the handshake.
- Reset during MUL_WAIT of term 2 -> next cycle all outputs 0 and state IDLE; a new job of (1,1) -> `res_data`=1.
- Ignored start: `cmd_start` pulsed during FETCH and during RESULT -> no restart and no extra `clr_acc`.
- Saturation: `cfg_len`=2, pairs (-32768,-32768) twice:
  - Accumulated sum is 2^31.
  - With `MAC_SEQ_SAT_EN`: `res_data`=40'h00_7FFF_FFFF, `res_sat`=1.
  - Without it: `res_data`=40'h00_8000_0000.
